// File: rtl/sysref_align_pkg.sv
// sysref_align_pkg
// Shared definitions for the SYSREF alignment controller:
//   - state_t        : 3-bit FSM state encoding
//   - MISS_W         : width of the misaligned-edge counter (16)
//   - miss_sat_inc() : saturating increment for the misaligned-edge counter
package sysref_align_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SEEK    = 3'd1,
      ST_MEASURE = 3'd2,
      ST_LOCKED  = 3'd3,
      ST_ERR     = 3'd4
   } state_t;

   localparam int MISS_W = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [MISS_W-1:0] miss_sat_inc(input logic [MISS_W-1:0] i_val);
      if (i_val == {MISS_W{1'b1}}) begin
         return i_val;
      end else begin
         return i_val + 16'd1;
      end
   endfunction

endpackage

// File: rtl/sysref_period_meter.sv
// sysref_period_meter
// Rising-edge detector and edge-to-edge period counter for the resynchronized
// SYSREF input.
// Ports:
//   i_clk, i_rst     : clock, asynchronous active-high reset
//   i_sysref         : SYSREF, already in the i_clk domain
//   i_clr            : restart measurement (clears counter, first-edge flag, o_meas_period)
//   o_edge           : rising edge this cycle (suppressed while i_clr is high)
//   o_period         : cycles since the previous edge, valid on o_edge
//   o_sat            : period counter has reached all-ones (SYSREF lost)
//   o_meas_period    : last measured period, updated the cycle after an edge
module sysref_period_meter
   import sysref_align_pkg::*;
#(
   parameter int PERIOD_W = 16
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_sysref,
   input  logic                i_clr,
   output logic                o_edge,
   output logic [PERIOD_W-1:0] o_period,
   output logic                o_sat,
   output logic [PERIOD_W-1:0] o_meas_period
);

   localparam logic [PERIOD_W-1:0] CNT_MAX  = {PERIOD_W{1'b1}};
   localparam logic [PERIOD_W-1:0] CNT_ZERO = {PERIOD_W{1'b0}};
   localparam logic [PERIOD_W-1:0] CNT_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};

   logic                r_sysref_d;
   logic                r_armed;
   logic                r_seen;
   logic [PERIOD_W-1:0] r_cnt;
   logic [PERIOD_W-1:0] r_meas;
   logic                w_raw_edge;

   // r_armed stays low for the first cycle after reset so that a SYSREF
   // already high at reset release is not mistaken for a rising edge.
   assign w_raw_edge    = r_armed & i_sysref & ~r_sysref_d;
   assign o_edge        = w_raw_edge & ~i_clr;
   assign o_period      = r_cnt;
   assign o_sat         = (r_cnt == CNT_MAX);
   assign o_meas_period = r_meas;

   // SYSREF history, edge-to-edge counter and measured-period latch
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sysref_d <= 1'b0;
         r_armed    <= 1'b0;
         r_seen     <= 1'b0;
         r_cnt      <= CNT_ZERO;
         r_meas     <= CNT_ZERO;
      end else begin
         r_sysref_d <= i_sysref;
         r_armed    <= 1'b1;
         if (i_clr) begin
            r_cnt  <= CNT_ZERO;
            r_seen <= 1'b0;
            r_meas <= CNT_ZERO;
         end else if (w_raw_edge) begin
            // The edge cycle itself is cycle 1 of the next period.
            r_cnt  <= CNT_ONE;
            r_seen <= 1'b1;
            if (r_seen) begin
               r_meas <= r_cnt;
            end else begin
               r_meas <= r_meas;
            end
         end else if (!o_sat) begin
            r_cnt <= r_cnt + CNT_ONE;
         end else begin
            r_cnt <= r_cnt;
         end
      end
   end

endmodule

// File: rtl/sysref_align_ctrl.sv
// sysref_align_ctrl
// Locks onto a periodic SYSREF, then regenerates an aligned one-cycle strobe
// from a free-running phase counter and flags any SYSREF edge that drifts.
// Optional feature: define SYSREF_ALIGN_MISSCNT_EN to build the misaligned-edge
// counter behind miss_cnt; otherwise miss_cnt is tied to zero.
// Parameters: PERIOD_W (counter width), LOCK_CNT (matching periods to lock),
//             TOL (+/- cycle tolerance on period and phase)
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   sysref_in    : SYSREF resynchronized to clk
//   enable       : level, low holds the block in IDLE
//   rearm        : pulse, restart acquisition
//   period_exp   : expected SYSREF period in clk cycles (2 .. 2^PERIOD_W-2)
//   strobe_out   : aligned one-cycle strobe
//   locked / err : state indicators
//   meas_period  : last measured edge-to-edge period
//   miss_cnt     : misaligned edges seen while locked (saturating)
module sysref_align_ctrl
   import sysref_align_pkg::*;
#(
   parameter int PERIOD_W = 16,
   parameter int LOCK_CNT = 4,
   parameter int TOL      = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sysref_in,
   input  logic                enable,
   input  logic                rearm,
   input  logic [PERIOD_W-1:0] period_exp,
   output logic                strobe_out,
   output logic                locked,
   output logic                err,
   output logic [PERIOD_W-1:0] meas_period,
   output logic [MISS_W-1:0]   miss_cnt
);

   localparam int                  MATCH_W = $clog2(LOCK_CNT + 1);
   localparam logic [MATCH_W-1:0]  MATCH_ZERO = {MATCH_W{1'b0}};
   localparam logic [MATCH_W-1:0]  MATCH_ONE  = {{(MATCH_W-1){1'b0}}, 1'b1};
   localparam logic [MATCH_W-1:0]  LOCK_V     = MATCH_W'(LOCK_CNT);
   localparam logic [PERIOD_W-1:0] PH_ZERO    = {PERIOD_W{1'b0}};
   localparam logic [PERIOD_W-1:0] PH_ONE     = {{(PERIOD_W-1){1'b0}}, 1'b1};
   localparam logic [PERIOD_W-1:0] TOL_V      = PERIOD_W'(TOL);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [MATCH_W-1:0]  r_match;
   logic [MATCH_W-1:0]  w_match_nxt;
   logic [MATCH_W-1:0]  w_match_inc;
   logic [PERIOD_W-1:0] r_phase;
   logic [PERIOD_W-1:0] w_phase_nxt;
   logic [PERIOD_W-1:0] w_phase_adv;
   logic [PERIOD_W-1:0] w_phase_rev;
   logic [PERIOD_W-1:0] w_phase_dist;
   logic [PERIOD_W:0]   w_period_diff;
   logic                w_in_tol;
   logic                w_phase_bad;
   logic                r_strobe;
   logic                r_locked;
   logic                r_err;
   logic                w_clr;
   logic                w_edge;
   logic                w_sat;
   logic [PERIOD_W-1:0] w_period;

   // Rearm is overridden by enable=0, so it only restarts the meter when enabled.
   assign w_clr = enable & rearm;

   sysref_period_meter #(
      .PERIOD_W (PERIOD_W)
   ) u_meter (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_sysref      (sysref_in),
      .i_clr         (w_clr),
      .o_edge        (w_edge),
      .o_period      (w_period),
      .o_sat         (w_sat),
      .o_meas_period (meas_period)
   );

   // |measured - expected| in one extra bit so neither side can underflow.
   assign w_period_diff = ({1'b0, w_period} >= {1'b0, period_exp})
                        ? ({1'b0, w_period} - {1'b0, period_exp})
                        : ({1'b0, period_exp} - {1'b0, w_period});
   assign w_in_tol      = (w_period_diff <= {1'b0, TOL_V});
   assign w_match_inc   = r_match + MATCH_ONE;

   // Phase 0 is where an aligned edge lands; distance is taken both ways round.
   assign w_phase_adv   = (r_phase >= (period_exp - PH_ONE)) ? PH_ZERO : (r_phase + PH_ONE);
   assign w_phase_rev   = period_exp - r_phase;
   assign w_phase_dist  = (r_phase <= w_phase_rev) ? r_phase : w_phase_rev;
   assign w_phase_bad   = (w_phase_dist > TOL_V);

   // Next-state, match count and phase counter; enable beats rearm beats edges
   always_comb begin
      w_state_nxt = r_state;
      w_match_nxt = r_match;
      w_phase_nxt = r_phase;
      if (!enable) begin
         w_state_nxt = ST_IDLE;
         w_match_nxt = MATCH_ZERO;
         w_phase_nxt = PH_ZERO;
      end else if (rearm) begin
         w_state_nxt = ST_SEEK;
         w_match_nxt = MATCH_ZERO;
         w_phase_nxt = PH_ZERO;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_SEEK;
               w_match_nxt = MATCH_ZERO;
            end
            ST_SEEK: begin
               if (w_edge) begin
                  w_state_nxt = ST_MEASURE;
                  w_match_nxt = MATCH_ZERO;
               end else begin
                  w_state_nxt = ST_SEEK;
               end
            end
            ST_MEASURE: begin
               if (w_edge && w_in_tol) begin
                  if (w_match_inc == LOCK_V) begin
                     w_state_nxt = ST_LOCKED;
                     w_match_nxt = MATCH_ZERO;
                     w_phase_nxt = PH_ONE;
                  end else begin
                     w_match_nxt = w_match_inc;
                  end
               end else if (w_edge) begin
                  w_match_nxt = MATCH_ZERO;
               end else begin
                  w_match_nxt = r_match;
               end
            end
            ST_LOCKED: begin
               if ((w_edge && w_phase_bad) || w_sat) begin
                  w_state_nxt = ST_ERR;
               end else begin
                  w_phase_nxt = w_phase_adv;
               end
            end
            ST_ERR: begin
               w_state_nxt = ST_ERR;
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_match_nxt = MATCH_ZERO;
               w_phase_nxt = PH_ZERO;
            end
         endcase
      end
   end

   // State, counters and registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_match  <= MATCH_ZERO;
         r_phase  <= PH_ZERO;
         r_strobe <= 1'b0;
         r_locked <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_match  <= w_match_nxt;
         r_phase  <= w_phase_nxt;
         // Strobe marks phase 1, the cycle after an aligned edge.
         r_strobe <= (w_state_nxt == ST_LOCKED) && (w_phase_nxt == PH_ONE);
         r_locked <= (w_state_nxt == ST_LOCKED);
         r_err    <= (w_state_nxt == ST_ERR);
      end
   end

   assign strobe_out = r_strobe;
   assign locked     = r_locked;
   assign err        = r_err;

`ifdef SYSREF_ALIGN_MISSCNT_EN
   logic [MISS_W-1:0] r_miss_cnt;
   logic              w_miss_evt;

   assign w_miss_evt = (r_state == ST_LOCKED) && (w_state_nxt == ST_ERR);

   // Saturating count of LOCKED->ERR faults; only rst clears it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_miss_cnt <= {MISS_W{1'b0}};
      end else if (w_miss_evt) begin
         r_miss_cnt <= miss_sat_inc(r_miss_cnt);
      end else begin
         r_miss_cnt <= r_miss_cnt;
      end
   end

   assign miss_cnt = r_miss_cnt;
`else
   assign miss_cnt = {MISS_W{1'b0}};
`endif

endmodule

// File: tb/tb_sysref_align_ctrl.sv
// tb_sysref_align_ctrl
// Directed bench for sysref_align_ctrl with default parameters
// (PERIOD_W=16, LOCK_CNT=4, TOL=0) and period_exp=100.
module tb_sysref_align_ctrl;

   localparam int PW = 16;
`ifdef SYSREF_ALIGN_MISSCNT_EN
   localparam int MISS_STEP = 1;
`else
   localparam int MISS_STEP = 0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          sysref_in;
   logic          enable;
   logic          rearm;
   logic [PW-1:0] period_exp;
   logic          strobe_out;
   logic          locked;
   logic          err;
   logic [PW-1:0] meas_period;
   logic [15:0]   miss_cnt;

   int n_vec       = 0;
   int n_err       = 0;
   int strobe_hits = 0;

   sysref_align_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .sysref_in   (sysref_in),
      .enable      (enable),
      .rearm       (rearm),
      .period_exp  (period_exp),
      .strobe_out  (strobe_out),
      .locked      (locked),
      .err         (err),
      .meas_period (meas_period),
      .miss_cnt    (miss_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock, then sample 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (strobe_out) strobe_hits++;
   endtask

   // SYSREF rising edge 'gap' cycles after the previous one (one-cycle pulse).
   task automatic pulse(input int gap);
      strobe_hits = 0;
      sysref_in   = 1'b0;
      repeat (gap - 1) tick();
      sysref_in = 1'b1;
      tick();
      sysref_in = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int pat[7];
      int w;
      pat = '{100, 100, 97, 100, 100, 100, 100};
      rst = 1'b1; enable = 1'b0; rearm = 1'b0; sysref_in = 1'b1; period_exp = 16'd100;
      repeat (3) tick();
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_err",    32'(err), 32'd0);
      chk("rst_strobe", 32'(strobe_out), 32'd0);
      chk("rst_meas",   32'(meas_period), 32'd0);
      chk("rst_miss",   32'(miss_cnt), 32'd0);

      // SYSREF already high at reset release must not count as an edge.
      rst = 1'b0; enable = 1'b1;
      repeat (5) tick();

      // Lock on the 5th edge, strobe right after it and every 100 cycles.
      for (int k = 1; k <= 5; k++) begin
         pulse(100);
         chk("lock_locked", 32'(locked), 32'(k == 5));
         chk("lock_meas",   32'(meas_period), (k == 1) ? 32'd0 : 32'd100);
      end
      chk("lock_strobe", 32'(strobe_out), 32'd1);
      chk("lock_err",    32'(err), 32'd0);
      for (int k = 0; k < 2; k++) begin
         pulse(100);
         chk("lock_hits",   32'(strobe_hits), 32'd1);
         chk("lock_strobe", 32'(strobe_out), 32'd1);
      end

      // Edge 3 cycles late -> ERR, strobe stops, sticky.
      pulse(103);
      chk("late_err",    32'(err), 32'd1);
      chk("late_locked", 32'(locked), 32'd0);
      chk("late_strobe", 32'(strobe_out), 32'd0);
      chk("late_meas",   32'(meas_period), 32'd103);
      chk("late_hits",   32'(strobe_hits), 32'd1);
      chk("late_miss",   32'(miss_cnt), 32'(MISS_STEP));
      strobe_hits = 0;
      repeat (200) tick();
      chk("err_sticky", 32'(err), 32'd1);
      chk("err_nostrb", 32'(strobe_hits), 32'd0);

      // Rearm coincident with an edge: edge ignored, five more edges to lock.
      sysref_in = 1'b1; rearm = 1'b1;
      tick();
      sysref_in = 1'b0; rearm = 1'b0;
      chk("rearm_err",  32'(err), 32'd0);
      chk("rearm_meas", 32'(meas_period), 32'd0);
      for (int k = 1; k <= 5; k++) begin
         pulse(100);
         chk("rearm_locked", 32'(locked), 32'(k == 5));
      end

      // Match count restarts on the 97-cycle period.
      rearm = 1'b1;
      tick();
      rearm = 1'b0;
      chk("rst_match_locked", 32'(locked), 32'd0);
      pulse(100);
      for (int k = 0; k < 7; k++) begin
         pulse(pat[k]);
         chk("match_locked", 32'(locked), 32'(k == 6));
         if (k == 2) chk("match_meas97", 32'(meas_period), 32'd97);
      end

      // SYSREF lost: counter saturates 65535 cycles after the last edge.
      w = 0;
      strobe_hits = 0;
      while (!err && w < 70000) begin
         tick();
         w++;
      end
      chk("sat_cycles", 32'(w), 32'd65535);
      chk("sat_hits",   32'(strobe_hits), 32'd655);
      chk("sat_miss",   32'(miss_cnt), 32'(2 * MISS_STEP));

      // enable=0 wins over rearm and drops to IDLE.
      enable = 1'b0; rearm = 1'b1;
      tick();
      rearm = 1'b0;
      chk("dis_err",    32'(err), 32'd0);
      chk("dis_locked", 32'(locked), 32'd0);
      enable = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         pulse(100);
         chk("relock_locked", 32'(locked), 32'(k == 5));
      end

      // Asynchronous reset mid-cycle while locked and strobing.
      #2 rst = 1'b1;
      #1;
      chk("arst_locked", 32'(locked), 32'd0);
      chk("arst_strobe", 32'(strobe_out), 32'd0);
      chk("arst_err",    32'(err), 32'd0);
      chk("arst_meas",   32'(meas_period), 32'd0);
      chk("arst_miss",   32'(miss_cnt), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sysref_align_ctrl.md
SYSREF_ALIGN_CTRL -- requirements
Module: sysref_align_ctrl

Interface
REQ-001 SHALL have parameter PERIOD_W, default 16: width of the period counters and period ports.
REQ-002 SHALL have parameter LOCK_CNT, default 4: consecutive matching SYSREF periods required to lock.
REQ-003 SHALL have parameter TOL, default 0: allowed +/- cycle deviation of a SYSREF edge from the expected phase.
REQ-004 SHALL have port clk, input, 1: single clock for all logic (clkadc3_300 domain).
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port sysref_in, input, 1: pl_sysref, already resynchronized to clk.
REQ-007 SHALL have port enable, input, 1: level; low forces IDLE.
REQ-008 SHALL have port rearm, input, 1: single-cycle pulse; restarts acquisition from any state.
REQ-009 SHALL have port period_exp, input, PERIOD_W: expected SYSREF period in clk cycles; valid range 2..2^PERIOD_W-2.
REQ-010 SHALL have port strobe_out, output, 1: one-cycle aligned strobe.
REQ-011 SHALL have port locked, output, 1: high only in LOCKED.
REQ-012 SHALL have port err, output, 1: high only in ERR.
REQ-013 SHALL have port meas_period, output, PERIOD_W: last measured edge-to-edge period.
REQ-014 SHALL have port miss_cnt, output, 16: count of misaligned edges seen while LOCKED.

Function
REQ-015 SHALL detect a rising edge as sysref_in=1 with its registered copy=0; detection is combinational from the register.
REQ-016 SHALL count clk cycles between rising edges; the counter saturates at all-ones and does not wrap.
REQ-017 SHALL latch the count into meas_period on each edge after the first, one cycle after the edge.
REQ-018 SHALL implement FSM states IDLE, SEEK, MEASURE, LOCKED and ERR.
REQ-019 IDLE SHALL go to SEEK when enable=1.
REQ-020 SEEK SHALL go to MEASURE on the first edge, with the match count cleared.
REQ-021 MEASURE, on each edge: a period within period_exp+/-TOL SHALL increment the match count; any other period SHALL clear it to 0 and stay in MEASURE.
REQ-022 MEASURE SHALL go to LOCKED on the edge that brings the match count to LOCK_CNT.
REQ-023 On entry to LOCKED, a phase counter SHALL load 1 and free-run modulo period_exp.
REQ-024 strobe_out SHALL pulse on the cycle after the locking edge, and every period_exp cycles after that.
REQ-025 In LOCKED, an edge with phase distance from 0 greater than TOL, or a saturated period counter (lost SYSREF), SHALL go to ERR next cycle, increment miss_cnt, and stop the strobe.
REQ-026 ERR SHALL be sticky until rearm or enable=0.
REQ-027 rearm in any state SHALL go to SEEK next cycle and clear meas_period, the match count and strobe_out.
REQ-028 If rearm and an edge occur in the same cycle, rearm SHALL win and the edge SHALL be ignored.
REQ-029 enable=0 SHALL take priority over rearm and force IDLE next cycle.
REQ-030 miss_cnt SHALL saturate at 16'hFFFF and clear only on rst.
REQ-031 A change to period_exp while LOCKED is unsupported; the bench SHALL not exercise it.

Reset
REQ-032 rst SHALL asynchronously force: state IDLE, strobe_out=0, locked=0, err=0, meas_period=0, miss_cnt=0, all counters 0, sysref register 0.
REQ-033 After rst deasserts, the first edge SHALL NOT be detected if sysref_in was already high.

Configuration
REQ-034 With macro SYSREF_ALIGN_MISSCNT_EN defined, miss_cnt SHALL count per REQ-025 and REQ-030.
REQ-035 Without SYSREF_ALIGN_MISSCNT_EN, miss_cnt SHALL be tied to 0 and no counter register SHALL be built.

Structure
REQ-036 Package sysref_align_pkg SHALL hold the FSM state encoding (3-bit) and the miss counter width constant (16).
REQ-037 Edge detection, the period counter and meas_period SHALL sit in one sub-module, sysref_period_meter; the FSM and phase counter SHALL stay in the top.

Verification
REQ-038 Bench SHALL cover: period_exp=100, edges every 100 cycles, TOL=0 -> locked rises on the 5th edge; strobe_out one cycle after that edge, then every 100 cycles.
REQ-039 Bench SHALL cover: after lock, one edge at 103 cycles, TOL=0 -> err=1 next cycle, miss_cnt=1, strobe_out stops.
REQ-040 Bench SHALL cover: in MEASURE, periods 100,100,97,100,100,100,100 -> match count resets at 97; lock on the 4th consecutive 100.
REQ-041 Bench SHALL cover: lock, then sysref_in held low for 65535 cycles -> ERR on saturation.
REQ-042 Bench SHALL cover: rearm coincident with an edge while in ERR -> SEEK; that edge is ignored; lock on the 5th subsequent edge.
REQ-043 Bench SHALL cover: rst asserted mid-LOCKED, asynchronously -> all outputs 0 in the same cycle; with the macro undefined, miss_cnt stays 0 throughout.
